// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Shares one memory read channel between icache and dcache, holding
//            each grant for a full burst; dcache writes pass straight through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    // icache read port
    input  logic [ADDR_W-1:0] ram_raddr_icache_i,
    input  logic              ram_raddr_valid_icache_i,
    input  logic [7:0]        ram_rmask_icache_i,
    input  logic [3:0]        ram_rsize_icache_i,
    input  logic [7:0]        ram_rlen_icache_i,
    output logic              ram_rdata_ready_icache_o,
    output logic [DATA_W-1:0] ram_rdata_icache_o,
    // dcache read port
    input  logic [ADDR_W-1:0] ram_raddr_dcache_i,
    input  logic              ram_raddr_valid_dcache_i,
    input  logic [7:0]        ram_rmask_dcache_i,
    input  logic [3:0]        ram_rsize_dcache_i,
    input  logic [7:0]        ram_rlen_dcache_i,
    output logic              ram_rdata_ready_dcache_o,
    output logic [DATA_W-1:0] ram_rdata_dcache_o,
    // dcache write port
    input  logic [ADDR_W-1:0] ram_waddr_dcache_i,
    input  logic              ram_waddr_valid_dcache_i,
    input  logic [7:0]        ram_wmask_dcache_i,
    input  logic [3:0]        ram_wsize_dcache_i,
    input  logic [7:0]        ram_wlen_dcache_i,
    input  logic [DATA_W-1:0] ram_wdata_dcache_i,
    output logic              ram_wdata_ready_dcache_o,
    // memory read channel
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic              ram_raddr_valid_o,
    output logic [7:0]        ram_rmask_o,
    output logic [3:0]        ram_rsize_o,
    output logic [7:0]        ram_rlen_o,
    input  logic              ram_rdata_ready_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    // memory write channel
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic              ram_waddr_valid_o,
    output logic [7:0]        ram_wmask_o,
    output logic [3:0]        ram_wsize_o,
    output logic [7:0]        ram_wlen_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic              ram_wdata_ready_i,
    output logic              arb_busy_o
);

    localparam logic PRIO_DC = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ICACHE = 2'd1,
        ARB_DCACHE = 2'd2
    } arb_state_t;

    arb_state_t state_q, state_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [7:0] rlen_q, rlen_d;
    logic       last_dc_q, last_dc_d;   // 1 = dcache held the most recent grant

    logic own_ic, own_dc, own_valid, rd_hs, grant_dc, grant_ic;

    assign own_ic    = (state_q == ARB_ICACHE);
    assign own_dc    = (state_q == ARB_DCACHE);
    assign own_valid = (own_ic & ram_raddr_valid_icache_i) | (own_dc & ram_raddr_valid_dcache_i);
    assign rd_hs     = ram_raddr_valid_o & ram_rdata_ready_i;

    // On a tie the dcache wins under fixed priority, otherwise whoever did not go last
    assign grant_dc = ram_raddr_valid_dcache_i &
                      (~ram_raddr_valid_icache_i | PRIO_DC | ~last_dc_q);
    assign grant_ic = ram_raddr_valid_icache_i & ~grant_dc;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rlen_d     = rlen_q;
        last_dc_d  = last_dc_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_dc) begin
                    state_d    = ARB_DCACHE;
                    rlen_d     = ram_rlen_dcache_i;
                    beat_cnt_d = 8'd0;
                    last_dc_d  = 1'b1;
                end else if (grant_ic) begin
                    state_d    = ARB_ICACHE;
                    rlen_d     = ram_rlen_icache_i;
                    beat_cnt_d = 8'd0;
                    last_dc_d  = 1'b0;
                end
            end
            ARB_ICACHE, ARB_DCACHE: begin
                if (!own_valid) begin
                    state_d    = ARB_IDLE;
                    beat_cnt_d = 8'd0;
                end else if (rd_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == rlen_q) begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            beat_cnt_q <= 8'd0;
            rlen_q     <= 8'd0;
            last_dc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rlen_q     <= rlen_d;
            last_dc_q  <= last_dc_d;
        end
    end

    always_comb begin
        ram_raddr_o       = '0;
        ram_raddr_valid_o = 1'b0;
        ram_rmask_o       = 8'd0;
        ram_rsize_o       = 4'd0;
        ram_rlen_o        = 8'd0;
        if (own_ic) begin
            ram_raddr_o       = ram_raddr_icache_i;
            ram_raddr_valid_o = ram_raddr_valid_icache_i;
            ram_rmask_o       = ram_rmask_icache_i;
            ram_rsize_o       = ram_rsize_icache_i;
            ram_rlen_o        = ram_rlen_icache_i;
        end else if (own_dc) begin
            ram_raddr_o       = ram_raddr_dcache_i;
            ram_raddr_valid_o = ram_raddr_valid_dcache_i;
            ram_rmask_o       = ram_rmask_dcache_i;
            ram_rsize_o       = ram_rsize_dcache_i;
            ram_rlen_o        = ram_rlen_dcache_i;
        end
    end

    assign ram_rdata_ready_icache_o = own_ic & rd_hs;
    assign ram_rdata_ready_dcache_o = own_dc & rd_hs;
    assign ram_rdata_icache_o       = ram_rdata_i;
    assign ram_rdata_dcache_o       = ram_rdata_i;
    assign arb_busy_o               = (state_q != ARB_IDLE);

    assign ram_waddr_o              = ram_waddr_dcache_i;
    assign ram_waddr_valid_o        = ram_waddr_valid_dcache_i;
    assign ram_wmask_o              = ram_wmask_dcache_i;
    assign ram_wsize_o              = ram_wsize_dcache_i;
    assign ram_wlen_o               = ram_wlen_dcache_i;
    assign ram_wdata_o              = ram_wdata_dcache_i;
    assign ram_wdata_ready_dcache_o = ram_wdata_ready_i;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Purpose  : Scoreboard bench for cache_mem_arbiter, round-robin and fixed
//            priority instances driven in parallel, one observed at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] ic_addr, dc_addr, w_addr;
    logic        ic_v, dc_v, w_v;
    logic [7:0]  ic_mask, dc_mask, w_mask, ic_len, dc_len, w_len;
    logic [3:0]  ic_size, dc_size, w_size;
    logic [63:0] w_data, mem_rdata;
    logic        mem_rready, mem_wready;

    logic [1:0]        a_rdy_ic, a_rdy_dc, a_rvalid, a_wready, a_wvalid, a_busy;
    logic [1:0][63:0]  a_rdata_ic, a_rdata_dc, a_wdata;
    logic [1:0][31:0]  a_raddr, a_waddr;
    logic [1:0][7:0]   a_rmask, a_rlen, a_wmask, a_wlen;
    logic [1:0][3:0]   a_rsize, a_wsize;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cache_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .FIXED_PRIO(g)) u_dut (
            .clk(clk), .rst(rst),
            .ram_raddr_icache_i(ic_addr), .ram_raddr_valid_icache_i(ic_v),
            .ram_rmask_icache_i(ic_mask), .ram_rsize_icache_i(ic_size),
            .ram_rlen_icache_i(ic_len), .ram_rdata_ready_icache_o(a_rdy_ic[g]),
            .ram_rdata_icache_o(a_rdata_ic[g]),
            .ram_raddr_dcache_i(dc_addr), .ram_raddr_valid_dcache_i(dc_v),
            .ram_rmask_dcache_i(dc_mask), .ram_rsize_dcache_i(dc_size),
            .ram_rlen_dcache_i(dc_len), .ram_rdata_ready_dcache_o(a_rdy_dc[g]),
            .ram_rdata_dcache_o(a_rdata_dc[g]),
            .ram_waddr_dcache_i(w_addr), .ram_waddr_valid_dcache_i(w_v),
            .ram_wmask_dcache_i(w_mask), .ram_wsize_dcache_i(w_size),
            .ram_wlen_dcache_i(w_len), .ram_wdata_dcache_i(w_data),
            .ram_wdata_ready_dcache_o(a_wready[g]),
            .ram_raddr_o(a_raddr[g]), .ram_raddr_valid_o(a_rvalid[g]),
            .ram_rmask_o(a_rmask[g]), .ram_rsize_o(a_rsize[g]), .ram_rlen_o(a_rlen[g]),
            .ram_rdata_ready_i(mem_rready), .ram_rdata_i(mem_rdata),
            .ram_waddr_o(a_waddr[g]), .ram_waddr_valid_o(a_wvalid[g]),
            .ram_wmask_o(a_wmask[g]), .ram_wsize_o(a_wsize[g]), .ram_wlen_o(a_wlen[g]),
            .ram_wdata_o(a_wdata[g]), .ram_wdata_ready_i(mem_wready),
            .arb_busy_o(a_busy[g])
        );
    end

    // sel picks which instance the memory model, requesters and monitor observe
    logic         sel;
    logic         m_rdy_ic, m_rdy_dc, m_rvalid, m_busy, m_wready;
    logic [63:0]  m_rdata_ic, m_rdata_dc;
    logic [31:0]  m_raddr;
    logic [51:0]  m_rreq;
    logic [116:0] m_w;
    assign m_rdy_ic   = a_rdy_ic[sel];
    assign m_rdy_dc   = a_rdy_dc[sel];
    assign m_rvalid   = a_rvalid[sel];
    assign m_busy     = a_busy[sel];
    assign m_wready   = a_wready[sel];
    assign m_rdata_ic = a_rdata_ic[sel];
    assign m_rdata_dc = a_rdata_dc[sel];
    assign m_raddr    = a_raddr[sel];
    assign m_rreq     = {a_raddr[sel], a_rmask[sel], a_rsize[sel], a_rlen[sel]};
    assign m_w        = {a_waddr[sel], a_wvalid[sel], a_wmask[sel], a_wsize[sel],
                         a_wlen[sel], a_wdata[sel]};

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0]  exp_ic[$];
    logic [63:0]  exp_dc[$];
    logic [116:0] exp_w[$];
    logic [51:0]  exp_grant[$];
    bit   abort = 1'b0;
    bit   busy_prev = 1'b0;
    bit   mem_hs = 1'b0;
    int   mem_delay = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: actual=event required=no event", name);
    endtask

    task automatic push_grant(input bit dc, input logic [31:0] addr, input logic [7:0] len);
        exp_grant.push_back({addr, dc ? 8'h0F : 8'hFF, dc ? 4'd2 : 4'd3, len});
    endtask

    // Requester: raise valid, wait for rlen+1 beats, drop valid one edge later unless keep
    task automatic req(input bit dc, input logic [31:0] addr, input logic [7:0] len, input bit keep);
        int n = 0;
        int cyc = 0;
        if (dc) begin
            dc_v = 1'b1; dc_addr = addr; dc_len = len; dc_mask = 8'h0F; dc_size = 4'd2;
        end else begin
            ic_v = 1'b1; ic_addr = addr; ic_len = len; ic_mask = 8'hFF; ic_size = 4'd3;
        end
        for (int i = 0; i <= int'(len); i++) begin
            if (dc) exp_dc.push_back({addr, 32'h1234 + 32'(i)});
            else    exp_ic.push_back({addr, 32'h1234 + 32'(i)});
        end
        while (n <= int'(len) && !abort) begin
            @(negedge clk);
            if (abort) break;
            if (dc ? m_rdy_dc : m_rdy_ic) n++;
            cyc++;
            if (cyc > 400) begin
                fail("req_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep || abort) begin
            if (dc) dc_v = 1'b0;
            else    ic_v = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Memory model: optional start delay, data = {addr, 0x1234 + beat}
    int mem_beat = 0;
    int mem_wait = 0;
    initial begin
        mem_rready = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!m_rvalid) begin
                mem_beat = 0; mem_wait = 0; mem_rready = 1'b0;
            end else begin
                if (mem_hs) mem_beat++;
                if (mem_wait < mem_delay) begin
                    mem_wait++;
                    mem_rready = 1'b0;
                end else begin
                    mem_rready = 1'b1;
                end
                mem_rdata = {m_raddr, 32'h1234 + 32'(mem_beat)};
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a new grant
    initial begin
        forever begin
            @(negedge clk);
            mem_hs = m_rvalid & mem_rready;
            if (m_rdy_ic) begin
                if (exp_ic.size() == 0) fail("ic_extra_beat");
                else chk("ic_rdata", 128'(m_rdata_ic), 128'(exp_ic.pop_front()));
            end
            if (m_rdy_dc) begin
                if (exp_dc.size() == 0) fail("dc_extra_beat");
                else chk("dc_rdata", 128'(m_rdata_dc), 128'(exp_dc.pop_front()));
            end
            if (m_wready) begin
                if (exp_w.size() == 0) fail("w_extra_beat");
                else chk("w_passthru", 128'(m_w), 128'(exp_w.pop_front()));
            end
            if (m_busy && !busy_prev) begin
                if (exp_grant.size() == 0) fail("extra_grant");
                else chk("grant_req", 128'(m_rreq), 128'(exp_grant.pop_front()));
            end
            busy_prev = m_busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; rst = 1'b1;
        ic_v = 1'b1; ic_addr = 32'h1111; ic_mask = 8'hFF; ic_size = 4'd3; ic_len = 8'd7;
        dc_v = 1'b1; dc_addr = 32'h2222; dc_mask = 8'h0F; dc_size = 4'd2; dc_len = 8'd7;
        w_v = 1'b0; w_addr = '0; w_mask = '0; w_size = '0; w_len = '0; w_data = '0;
        mem_wready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_rvalid", 128'(m_rvalid), 128'(0));
        chk("rst_busy", 128'(m_busy), 128'(0));
        chk("rst_rdy", 128'({m_rdy_ic, m_rdy_dc}), 128'(0));
        chk("rst_rreq", 128'(m_rreq), 128'(0));
        @(posedge clk);
        #1 ic_v = 1'b0; dc_v = 1'b0; rst = 1'b0;

        // Icache alone, 8 beats, one cycle of arbitration latency
        @(posedge clk); #1;
        push_grant(0, 32'h1000, 8'd7);
        fork
            req(0, 32'h1000, 8'd7, 0);
            begin
                int hi = 0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (m_rvalid) hi++;
                    if (i == 0) chk("t1_lat0", 128'(m_rvalid), 128'(0));
                    if (i == 1) chk("t1_lat1", 128'(m_rvalid), 128'(1));
                    if (i == 9) chk("t1_busy_fall", 128'(m_busy), 128'(0));
                end
                chk("t1_valid_cycles", 128'(hi), 128'(8));
            end
        join

        // Round-robin: tie after reset goes to dcache; dcache re-request ties and loses
        @(posedge clk); #1;
        do_reset();
        push_grant(1, 32'h3000, 8'd7);
        push_grant(0, 32'h2000, 8'd7);
        push_grant(1, 32'h3100, 8'd3);
        fork
            begin
                req(1, 32'h3000, 8'd7, 1);
                req(1, 32'h3100, 8'd3, 0);
            end
            req(0, 32'h2000, 8'd7, 0);
        join

        // Fixed priority: dcache wins every tie, icache waits until dcache goes idle
        sel = 1'b1;
        do_reset();
        push_grant(1, 32'h3000, 8'd3);
        push_grant(1, 32'h3100, 8'd3);
        push_grant(1, 32'h3200, 8'd3);
        push_grant(0, 32'h2000, 8'd3);
        fork
            begin
                req(1, 32'h3000, 8'd3, 1);
                req(1, 32'h3100, 8'd3, 1);
                req(1, 32'h3200, 8'd3, 0);
            end
            req(0, 32'h2000, 8'd3, 0);
        join
        sel = 1'b0;
        do_reset();

        // Uncached single beat with slow memory
        mem_delay = 3;
        push_grant(1, 32'hDEADBEEF, 8'd0);
        req(1, 32'hDEADBEEF, 8'd0, 0);
        @(negedge clk);
        chk("t4_idle", 128'(m_busy), 128'(0));
        mem_delay = 0;

        // Dcache arrives mid icache burst; a write burst runs alongside
        @(posedge clk); #1;
        push_grant(0, 32'h4000, 8'd7);
        push_grant(1, 32'h5000, 8'd3);
        fork
            begin
                req(0, 32'h4000, 8'd7, 0);
                @(negedge clk);
                chk("t5_idle_gap", 128'(m_busy), 128'(0));
                @(negedge clk);
                chk("t5_dc_grant", 128'({m_busy, m_raddr}), 128'({1'b1, 32'h5000}));
            end
            begin
                int cnt = 0;
                for (int k = 0; k < 50 && cnt < 3; k++) begin
                    @(negedge clk);
                    if (m_rdy_ic) cnt++;
                end
                @(posedge clk); #1;
                req(1, 32'h5000, 8'd3, 0);
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk); #1;
                    w_v = 1'b1; w_addr = 32'h8000 + 32'(i * 8); w_mask = 8'hFF;
                    w_size = 4'd3; w_len = 8'd7; w_data = 64'hCAFE_0000_0000_0000 + 64'(i);
                    mem_wready = 1'b1;
                    exp_w.push_back({w_addr, 1'b1, w_mask, w_size, w_len, w_data});
                end
                @(posedge clk); #1;
                w_v = 1'b0; mem_wready = 1'b0;
            end
        join

        // Reset at beat 4 of a dcache burst, then a clean icache burst
        @(posedge clk); #1;
        push_grant(1, 32'h6000, 8'd7);
        fork
            req(1, 32'h6000, 8'd7, 0);
            begin
                int cnt = 0;
                for (int k = 0; k < 50 && cnt < 4; k++) begin
                    @(negedge clk);
                    if (m_rdy_dc) cnt++;
                end
                #1 rst = 1'b1; abort = 1'b1;
                #1;
                chk("t6_rst_async", 128'({m_rvalid, m_busy, m_rdy_dc}), 128'(0));
                exp_dc.delete();
                @(negedge clk);
                @(negedge clk);
                #1 rst = 1'b0;
            end
        join
        abort = 1'b0;
        @(posedge clk); #1;
        push_grant(0, 32'h7000, 8'd3);
        req(0, 32'h7000, 8'd3, 0);

        repeat (3) @(negedge clk);
        chk("end_ic_queue", 128'(exp_ic.size()), 128'(0));
        chk("end_dc_queue", 128'(exp_dc.size()), 128'(0));
        chk("end_w_queue", 128'(exp_w.size()), 128'(0));
        chk("end_grant_queue", 128'(exp_grant.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
